// File: rtl/branch_resolve_ctrl.sv
// Sequences the ID-stage beq/bne comparator: stalls until operands are clean, resolves one cycle after cmp_en.
// Optional counters under BRANCH_STATS_EN; best-case redirect one cycle after detect, WAIT is unbounded.
module branch_resolve_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_op,
  input  logic [WIDTH-1:0] id_target,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             kill,
  input  logic             cmp_zero,
  output logic             cmp_en,
  output logic             stall,
  output logic             pc_src,
  output logic [WIDTH-1:0] pc_target,
  output logic             flush,
  output logic             busy,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      nottaken_cnt,
  output logic [31:0]      stall_cnt
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_EVAL = 2'b10;

  localparam logic [1:0] OP_BEQ = 2'b01;
  localparam logic [1:0] OP_BNE = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_is_bne;
  logic [WIDTH-1:0] r_target;

  logic w_detect;
  logic w_ready;
  logic w_in_idle;
  logic w_in_wait;
  logic w_in_eval;
  logic w_capture;
  logic w_taken;
  logic w_quiet;

  assign w_detect  = id_valid & ((id_op == OP_BEQ) | (id_op == OP_BNE));
  assign w_ready   = rs_ready & rt_ready;
  assign w_in_idle = (r_state == S_IDLE);
  assign w_in_wait = (r_state == S_WAIT);
  assign w_in_eval = (r_state == S_EVAL);
  assign w_capture = w_in_idle & w_detect & ~kill;
  assign w_taken   = w_in_eval & (r_is_bne ? ~cmp_zero : cmp_zero);

  // Outputs are forced quiet during reset and kill so nothing leaks from a discarded branch.
  assign w_quiet = rst | kill;

  always_comb begin
    w_state_nxt = r_state;
    if (kill) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_detect) begin
            w_state_nxt = w_ready ? S_EVAL : S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_ready) begin
            w_state_nxt = S_EVAL;
          end
        end
        S_EVAL:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_bne <= 1'b0;
      r_target <= '0;
    end else if (w_capture) begin
      r_is_bne <= (id_op == OP_BNE);
      r_target <= id_target;
    end
  end

  always_comb begin
    stall  = 1'b0;
    cmp_en = 1'b0;
    pc_src = 1'b0;
    flush  = 1'b0;
    if (!w_quiet) begin
      stall  = (w_in_idle & w_detect) | w_in_wait;
      cmp_en = ((w_in_idle & w_detect) | w_in_wait) & w_ready;
      pc_src = w_taken;
      flush  = w_taken;
    end
  end

  assign pc_target = r_target;
  assign busy      = ~rst & ~w_in_idle;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_taken_cnt;
  logic [31:0] r_nottaken_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_cnt    <= '0;
      r_nottaken_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_in_eval && !kill) begin
        if (w_taken) begin
          r_taken_cnt <= r_taken_cnt + 32'd1;
        end else begin
          r_nottaken_cnt <= r_nottaken_cnt + 32'd1;
        end
      end
      if (w_in_wait) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign taken_cnt    = r_taken_cnt;
  assign nottaken_cnt = r_nottaken_cnt;
  assign stall_cnt    = r_stall_cnt;
`else
  assign taken_cnt    = '0;
  assign nottaken_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; inputs change 1 time unit after the rising edge, outputs sampled 2 units later.
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [1:0]  id_op;
  logic [31:0] id_target;
  logic        rs_ready;
  logic        rt_ready;
  logic        kill;
  logic        cmp_zero;
  logic        cmp_en;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        flush;
  logic        busy;
  logic [31:0] taken_cnt;
  logic [31:0] nottaken_cnt;
  logic [31:0] stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_target(id_target),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .kill(kill), .cmp_zero(cmp_zero),
    .cmp_en(cmp_en), .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .flush(flush), .busy(busy), .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt),
    .stall_cnt(stall_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_op = 2'b00; id_target = 32'h0;
    rs_ready = 1'b1; rt_ready = 1'b1; kill = 1'b0; cmp_zero = 1'b0;
  endtask

  task automatic run_branch(input logic [1:0] op, input logic [31:0] tgt, input logic cz, input int nready);
    cyc(); id_valid = 1'b1; id_op = op; id_target = tgt; rs_ready = 1'b1; rt_ready = (nready == 0);
    for (int i = 1; i <= nready; i++) begin
      cyc(); id_valid = 1'b0; rt_ready = (i == nready);
    end
    cyc(); id_valid = 1'b0; cmp_zero = cz;
    cyc(); idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    id_valid = 1'b1; id_op = 2'b01; id_target = 32'h1234_5678;
    #3;
    n_total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    n_total++; if (cmp_en !== 1'b0) $display("FAIL rst_cmp_en: got %b want 0", cmp_en); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (pc_target !== 32'h0) $display("FAIL rst_pc_target: got %h want 0", pc_target); else n_pass++;
    n_total++; if ({pc_src, flush} !== 2'b00) $display("FAIL rst_redirect: got %b want 00", {pc_src, flush}); else n_pass++;
    n_total++; if (taken_cnt !== 32'h0 || nottaken_cnt !== 32'h0 || stall_cnt !== 32'h0)
      $display("FAIL rst_counters: got %0d/%0d/%0d want 0/0/0", taken_cnt, nottaken_cnt, stall_cnt); else n_pass++;
    cyc(); cyc();
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_beq_taken();
    cyc(); id_valid = 1'b1; id_op = 2'b01; id_target = 32'h0040_0020; cmp_zero = 1'b1;
    #2;
    n_total++; if (stall !== 1'b1) $display("FAIL beq_stall: got %b want 1", stall); else n_pass++;
    n_total++; if (cmp_en !== 1'b1) $display("FAIL beq_cmp_en: got %b want 1", cmp_en); else n_pass++;
    n_total++; if (pc_src !== 1'b0) $display("FAIL beq_early_pc_src: got %b want 0", pc_src); else n_pass++;
    cyc(); id_valid = 1'b0; id_target = 32'hFFFF_0000;
    #2;
    n_total++; if (pc_src !== 1'b1) $display("FAIL beq_pc_src: got %b want 1", pc_src); else n_pass++;
    n_total++; if (flush !== 1'b1) $display("FAIL beq_flush: got %b want 1", flush); else n_pass++;
    n_total++; if (pc_target !== 32'h0040_0020) $display("FAIL beq_pc_target: got %h want 00400020", pc_target); else n_pass++;
    n_total++; if ({stall, cmp_en, busy} !== 3'b001) $display("FAIL beq_eval_ctl: got %b want 001", {stall, cmp_en, busy}); else n_pass++;
    cyc(); idle_inputs();
    #2;
    n_total++; if ({busy, pc_src, flush} !== 3'b000) $display("FAIL beq_done: got %b want 000", {busy, pc_src, flush}); else n_pass++;
  endtask

  task automatic test_bne_not_taken();
    cyc(); id_valid = 1'b1; id_op = 2'b10; id_target = 32'h0040_0080; cmp_zero = 1'b1;
    #2;
    n_total++; if ({stall, cmp_en} !== 2'b11) $display("FAIL bne_detect: got %b want 11", {stall, cmp_en}); else n_pass++;
    cyc();
    #2;
    n_total++; if ({pc_src, flush} !== 2'b00) $display("FAIL bne_redirect: got %b want 00", {pc_src, flush}); else n_pass++;
    n_total++; if ({stall, cmp_en} !== 2'b00) $display("FAIL bne_eval_no_accept: got %b want 00", {stall, cmp_en}); else n_pass++;
    cyc();
    #2;
    n_total++; if ({stall, busy} !== 2'b10) $display("FAIL bne_reaccept: got %b want 10", {stall, busy}); else n_pass++;
    cyc(); idle_inputs();
    cyc(); cyc();
  endtask

  task automatic test_ignored_ops();
    cyc(); id_valid = 1'b1; id_op = 2'b11;
    #2;
    n_total++; if ({stall, cmp_en} !== 2'b00) $display("FAIL reserved_op: got %b want 00", {stall, cmp_en}); else n_pass++;
    cyc(); id_valid = 1'b0; id_op = 2'b01;
    #2;
    n_total++; if ({stall, busy} !== 2'b00) $display("FAIL invalid_beq: got %b want 00", {stall, busy}); else n_pass++;
    cyc(); idle_inputs();
  endtask

  task automatic test_wait();
    cyc(); id_valid = 1'b1; id_op = 2'b01; id_target = 32'h0040_0100; rt_ready = 1'b0; cmp_zero = 1'b1;
    #2;
    n_total++; if ({stall, cmp_en} !== 2'b10) $display("FAIL wait_c1: got %b want 10", {stall, cmp_en}); else n_pass++;
    cyc(); id_valid = 1'b0; id_op = 2'b10; id_target = 32'hDEAD_BEEF;
    #2;
    n_total++; if ({stall, cmp_en, busy} !== 3'b101) $display("FAIL wait_c2: got %b want 101", {stall, cmp_en, busy}); else n_pass++;
    cyc(); rt_ready = 1'b1;
    #2;
    n_total++; if ({stall, cmp_en} !== 2'b11) $display("FAIL wait_c3: got %b want 11", {stall, cmp_en}); else n_pass++;
    cyc(); rt_ready = 1'b0; rs_ready = 1'b0;
    #2;
    n_total++; if ({pc_src, flush, stall} !== 3'b110) $display("FAIL wait_redirect: got %b want 110", {pc_src, flush, stall}); else n_pass++;
    n_total++; if (pc_target !== 32'h0040_0100) $display("FAIL wait_pc_target: got %h want 00400100", pc_target); else n_pass++;
    cyc(); idle_inputs();
    #2;
    n_total++; if (busy !== 1'b0) $display("FAIL wait_done: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_kill();
    cyc(); id_valid = 1'b1; id_op = 2'b01; id_target = 32'h0040_0200; rs_ready = 1'b0; cmp_zero = 1'b1;
    cyc(); id_valid = 1'b0; kill = 1'b1;
    #2;
    n_total++; if ({stall, cmp_en} !== 2'b00) $display("FAIL kill_wait_outs: got %b want 00", {stall, cmp_en}); else n_pass++;
    cyc(); kill = 1'b0; rs_ready = 1'b1;
    #2;
    n_total++; if ({busy, pc_src, flush} !== 3'b000) $display("FAIL kill_wait_idle: got %b want 000", {busy, pc_src, flush}); else n_pass++;
    cyc(); id_valid = 1'b1; id_op = 2'b01; id_target = 32'h0040_0300;
    cyc(); id_valid = 1'b0; kill = 1'b1;
    #2;
    n_total++; if ({pc_src, flush} !== 2'b00) $display("FAIL kill_eval_outs: got %b want 00", {pc_src, flush}); else n_pass++;
    cyc(); kill = 1'b0;
    #2;
    n_total++; if ({busy, pc_src, flush} !== 3'b000) $display("FAIL kill_eval_idle: got %b want 000", {busy, pc_src, flush}); else n_pass++;
    cyc(); idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    cyc(); id_valid = 1'b1; id_op = 2'b01; id_target = 32'h0040_0400; rt_ready = 1'b0; cmp_zero = 1'b1;
    cyc(); id_valid = 1'b0;
    #2;
    n_total++; if ({busy, stall} !== 2'b11) $display("FAIL rstmid_in_wait: got %b want 11", {busy, stall}); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if ({busy, stall, cmp_en, pc_src, flush} !== 5'b0) $display("FAIL rstmid_async: got %b want 00000", {busy, stall, cmp_en, pc_src, flush}); else n_pass++;
    n_total++; if (pc_target !== 32'h0) $display("FAIL rstmid_pc_target: got %h want 0", pc_target); else n_pass++;
    cyc(); rst = 1'b0; idle_inputs();
    cyc(); id_valid = 1'b1; id_op = 2'b01; id_target = 32'h0040_0500; cmp_zero = 1'b1;
    cyc(); id_valid = 1'b0;
    #2;
    n_total++; if ({pc_src, flush} !== 2'b11) $display("FAIL rstmid_resume: got %b want 11", {pc_src, flush}); else n_pass++;
    n_total++; if (pc_target !== 32'h0040_0500) $display("FAIL rstmid_resume_tgt: got %h want 00400500", pc_target); else n_pass++;
    cyc(); idle_inputs();
  endtask

  task automatic test_stats();
    logic [31:0] exp_t, exp_n, exp_s;
`ifdef BRANCH_STATS_EN
    exp_t = 32'd3; exp_n = 32'd2; exp_s = 32'd4;
`else
    exp_t = 32'd0; exp_n = 32'd0; exp_s = 32'd0;
`endif
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    run_branch(2'b01, 32'h0040_1000, 1'b1, 0);
    run_branch(2'b01, 32'h0040_1010, 1'b1, 0);
    run_branch(2'b01, 32'h0040_1020, 1'b1, 4);
    run_branch(2'b10, 32'h0040_1030, 1'b1, 0);
    run_branch(2'b10, 32'h0040_1040, 1'b1, 0);
    #2;
    n_total++; if (taken_cnt !== exp_t) $display("FAIL stats_taken: got %0d want %0d", taken_cnt, exp_t); else n_pass++;
    n_total++; if (nottaken_cnt !== exp_n) $display("FAIL stats_nottaken: got %0d want %0d", nottaken_cnt, exp_n); else n_pass++;
    n_total++; if (stall_cnt !== exp_s) $display("FAIL stats_stall: got %0d want %0d", stall_cnt, exp_s); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_ignored_ops();
    test_wait();
    test_kill();
    test_reset_mid_op();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequences the ID-stage beq/bne equality comparator in the pipelined MIPS core. The block detects a decoded branch and stalls fetch/decode until both source operands are free of pending writes. It then enables the comparator's operand capture, resolves the branch from the comparator's zero flag one cycle later, and drives PC redirect and IF/ID flush. It sits between the decode/hazard logic, the `equal` comparator and the PC-select mux.

## Interface
- WIDTH, 32, datapath/address width
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  valid instruction held in IF/ID
- id_op  in  2  00 none, 01 beq, 10 bne, 11 reserved (treated as none)
- id_target  in  WIDTH  branch target computed in ID
- rs_ready, rt_ready  in  1 each  operand free of pending write (no load in EX/MEM targeting it)
- kill  in  1  exception/flush from later stage; aborts branch in flight
- cmp_zero  in  1  comparator output, valid the cycle after cmp_en
- cmp_en  out  1  capture rs/rt into comparator operand registers
- stall  out  1  hold PC and IF/ID
- pc_src  out  1  select pc_target for next PC
- pc_target  out  WIDTH  latched branch target
- flush  out  1  squash IF/ID contents on next edge
- busy  out  1  FSM not in IDLE

## Operation
- Branch detect: id_valid=1 and id_op in {01,10}. Other id_op values are ignored.
- States: IDLE, WAIT, EVAL.
- IDLE: on detect, latch id_op and id_target and assert stall. If rs_ready&rt_ready, assert cmp_en and go to EVAL; otherwise go to WAIT.
- WAIT: assert stall. Once rs_ready&rt_ready, assert cmp_en and go to EVAL. There is no timeout; WAIT persists while operands are not ready.
- EVAL: stall=0. Compute taken = (op==beq) ? cmp_zero : ~cmp_zero.
  - If taken: pc_src=1, pc_target=latched target, flush=1.
  - Return to IDLE in all cases.
  - A new branch is not accepted in the EVAL cycle; detection resumes in the IDLE cycle that follows.
- kill=1 in any cycle forces IDLE on the next edge. While kill is high, pc_src, flush, cmp_en and stall are 0. kill has priority over EVAL resolution.
- Output decode:
  - pc_src and flush are combinational decodes of the EVAL state; both are 0 outside EVAL.
  - stall is a combinational decode of (IDLE&detect) | WAIT.
  - cmp_en is combinational.

## Timing
- Reset: all state and outputs are 0; the FSM is in IDLE and pc_target=0. Reset asserted mid-operation discards the branch and produces no redirect.
- Best-case latency:
  - Detect in cycle N, with stall=1 and cmp_en=1.
  - EVAL in N+1: pc_src/flush valid.
  - Next PC is the target at N+2.
- Each cycle of operand unreadiness adds one WAIT cycle. Resolution occurs in the cycle after the cycle where both ready signals are observed high.
- rs_ready and rt_ready are sampled only in IDLE-detect and WAIT. They may toggle freely elsewhere.
- id_op and id_target are sampled only at detect; they are held internally afterwards.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds 32-bit counters taken_cnt and nottaken_cnt (output ports), incremented in EVAL when not killed.
  - Adds stall_cnt, incremented each cycle in WAIT.
  - All counters wrap at 2^32, reset to 0 and are readable at any time.
- BRANCH_STATS_EN undefined: the same ports exist but are tied to 0, and no counter logic is built.

## Test plan
- beq with ready operands, cmp_zero=1, id_target=0x00400020 -> stall and cmp_en high for 1 cycle; next cycle pc_src=1, flush=1, pc_target=0x00400020.
- bne with ready operands, cmp_zero=1 -> one-cycle stall, EVAL with pc_src=0 and flush=0, FSM back in IDLE.
- beq with rt_ready low for 2 cycles, then high, cmp_zero=1 -> stall high for 3 cycles; cmp_en on the 3rd cycle; redirect on the 4th.
- kill asserted in WAIT, and separately in EVAL with taken conditions -> no pc_src/flush, IDLE next cycle, busy=0.
- rst pulsed during WAIT -> all outputs 0 immediately (asynchronously); a subsequent branch resolves normally.
- BRANCH_STATS_EN: 3 taken, 2 not-taken, and 4 wait cycles -> taken_cnt=3, nottaken_cnt=2, stall_cnt=4. Without the macro, all three read 0.
